output_port_alloc: RTL

// - Per-output-port switch allocator + crossbar slice; one instance per router output port, downstream of all P input queues.
// - Collects bit k of every input queue's dest_port_req; round-robin arbitrates; returns a one-hot grant; muxes the winner's flit to the link.
// - Tracks downstream buffer credits, so a flit is sent only when the next hop's input buffer has space.

---
 rtl/output_port_alloc_pkg.sv | 16 +
 rtl/output_port_alloc_rr_arbiter.sv | 36 +++
 rtl/output_port_alloc.sv | 121 ++++++++++++
 3 files changed

// File: rtl/output_port_alloc_pkg.sv
// Shared parameters and helpers for the per-output-port switch allocator.
package output_port_alloc_pkg;

  localparam int FW_DEF   = 64;
  localparam int P_DEF    = 7;
  localparam int B_DEF    = 4;
  localparam int R_FLG    = 36;
  localparam int X_FLG    = R_FLG + 12;
  localparam int CREDIT_W = B_DEF + 1;

  // Round-robin pointer width for a given number of competing inputs.
  function automatic int ptr_width(input int p);
    return (p > 1) ? $clog2(p) : 1;
  endfunction

endpackage

// File: rtl/output_port_alloc_rr_arbiter.sv
// Combinational round-robin arbiter: searches req upward from ptr, wrapping
// P-1 -> 0, and returns a one-hot grant plus the pointer for the next round.
module rr_arbiter
  import output_port_alloc_pkg::*;
#(
  parameter int P  = P_DEF,
  parameter int PW = ptr_width(P)
) (
  input  logic [P-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  input  logic          i_en,
  output logic [P-1:0]  o_gnt,
  output logic [PW-1:0] o_next_ptr
);

  logic w_found;
  int   w_idx;

  // First requester at or above the pointer wins; pointer moves past it.
  always_comb begin
    o_gnt      = '0;
    o_next_ptr = i_ptr;
    w_found    = 1'b0;
    w_idx      = 0;
    for (int i = 0; i < P; i++) begin
      w_idx = int'(i_ptr) + i;
      if (w_idx >= P) w_idx = w_idx - P;
      if (i_en && !w_found && i_req[w_idx]) begin
        w_found      = 1'b1;
        o_gnt[w_idx] = 1'b1;
        o_next_ptr   = (w_idx == P - 1) ? '0 : PW'(w_idx + 1);
      end
    end
  end

endmodule

// File: rtl/output_port_alloc.sv
// Per-output-port switch allocator and crossbar slice with downstream
// credit tracking. Optional macro OUTPUT_PORT_ALLOC_CREDIT_CHK_EN enables the
// sticky credit overflow flag and simulation-time grant/credit checks.
module output_port_alloc
  import output_port_alloc_pkg::*;
#(
  parameter int FW = FW_DEF,
  parameter int P  = P_DEF,
  parameter int B  = B_DEF
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [P-1:0]  i_port_req,
  input  logic [P*FW-1:0] i_flit_in,
  input  logic          i_credit_in,
  output logic [P-1:0]  o_grant,
  output logic [FW-1:0] o_flit_out,
  output logic          o_flit_out_wr,
  output logic          o_credit_err
);

  localparam int PW = ptr_width(P);
  localparam int CW = B + 1;
  localparam logic [CW-1:0] CREDIT_MAX = CW'(2**B);

  logic [PW-1:0] r_rr_ptr;
  logic [P-1:0]  r_grant;
  logic [CW-1:0] r_credit_cnt;
  logic [FW-1:0] r_flit_out;
  logic          r_flit_out_wr;

  logic [P-1:0]  w_eligible;
  logic [P-1:0]  w_gnt;
  logic [PW-1:0] w_next_ptr;
  logic          w_decision;
  logic          w_credit_ok;
  logic          w_overflow;
  logic [FW-1:0] w_flit_mux;

  // An input granted last cycle is masked so it has time to drop its request.
  assign w_eligible  = i_port_req & ~r_grant;
  assign w_credit_ok = (r_credit_cnt != '0);
  assign w_decision  = |w_gnt;
  assign w_overflow  = i_credit_in && !w_decision && (r_credit_cnt == CREDIT_MAX);

  rr_arbiter #(.P(P), .PW(PW)) u_arb (
    .i_req      (w_eligible),
    .i_ptr      (r_rr_ptr),
    .i_en       (w_credit_ok),
    .o_gnt      (w_gnt),
    .o_next_ptr (w_next_ptr)
  );

  // One-hot AND-OR mux selecting the granted input's flit.
  always_comb begin
    w_flit_mux = '0;
    for (int i = 0; i < P; i++) begin
      w_flit_mux = w_flit_mux | (i_flit_in[i*FW +: FW] & {FW{r_grant[i]}});
    end
  end

  // Arbitration state: grant register and round-robin pointer.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_grant  <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_grant <= w_gnt;
      if (w_decision) r_rr_ptr <= w_next_ptr;
    end
  end

  // Credit counter: decision consumes, credit_in returns, both cancel out.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_credit_cnt <= CREDIT_MAX;
    end else if (w_decision && !i_credit_in) begin
      r_credit_cnt <= r_credit_cnt - 1'b1;
    end else if (!w_decision && i_credit_in && (r_credit_cnt != CREDIT_MAX)) begin
      r_credit_cnt <= r_credit_cnt + 1'b1;
    end
  end

  // Output registers: flit is launched the cycle after the grant.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_flit_out    <= '0;
      r_flit_out_wr <= 1'b0;
    end else begin
      r_flit_out_wr <= |r_grant;
      if (|r_grant) r_flit_out <= w_flit_mux;
    end
  end

  assign o_grant       = r_grant;
  assign o_flit_out    = r_flit_out;
  assign o_flit_out_wr = r_flit_out_wr;

`ifdef OUTPUT_PORT_ALLOC_CREDIT_CHK_EN
  logic r_credit_err;

  // Sticky flag for a credit returned while the counter is already full.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_credit_err <= 1'b0;
    else if (w_overflow) r_credit_err <= 1'b1;
  end

  assign o_credit_err = r_credit_err;

  // Simulation checks on grant shape and credit usage.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      if (!$onehot0(r_grant)) $error("output_port_alloc: grant not one-hot %b", r_grant);
      if (w_decision && (r_credit_cnt == '0)) $error("output_port_alloc: grant with zero credit");
    end
  end
`else
  assign o_credit_err = 1'b0;
`endif

endmodule
